rename_table: RTL and testbench

- Two-lane speculative register alias table (RAT) plus architectural RAT.
- Sits in the rename stage, directly downstream of the physical-register freelist: consumes the two allocated pregs (req0_data/req1_data), maps logical sources to pregs, and emits the old destination preg for the ROB to free at commit.
- Recovers on ROB rollback by copying the architectural table, then replays walk entries, in lockstep with the freelist deq_ptr restore/walk.

---
 rtl/rename_table.sv | 163 ++++++++++++++++
 tb/tb_rename_table.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rename_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rename_table : two-lane speculative RAT plus architectural RAT with
//                rollback/walk recovery. Optional ports: RENAME_TABLE_DEBUG_EN
// Revision     : 1.0  initial release
// ---------------------------------------------------------------------------
`ifndef PREG_RANGE
`define PREG_RANGE 5:0
`endif
`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE     2'd0
`endif
`ifndef ROB_STATE_ROLLBACK
`define ROB_STATE_ROLLBACK 2'd1
`endif
`ifndef ROB_STATE_WALK
`define ROB_STATE_WALK     2'd2
`endif

module rename_table #(
  parameter int LREG_NUM = 32,
  parameter int LREG_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rn0_valid,
  input  logic [LREG_W-1:0] rn0_lrs1,
  input  logic [LREG_W-1:0] rn0_lrs2,
  input  logic [LREG_W-1:0] rn0_lrd,
  input  logic              rn0_rd_wen,
  input  logic [`PREG_RANGE] rn0_pd,
  output logic [`PREG_RANGE] rn0_prs1,
  output logic [`PREG_RANGE] rn0_prs2,
  output logic [`PREG_RANGE] rn0_old_pd,
  input  logic              rn1_valid,
  input  logic [LREG_W-1:0] rn1_lrs1,
  input  logic [LREG_W-1:0] rn1_lrs2,
  input  logic [LREG_W-1:0] rn1_lrd,
  input  logic              rn1_rd_wen,
  input  logic [`PREG_RANGE] rn1_pd,
  output logic [`PREG_RANGE] rn1_prs1,
  output logic [`PREG_RANGE] rn1_prs2,
  output logic [`PREG_RANGE] rn1_old_pd,
  input  logic              cm0_valid,
  input  logic [LREG_W-1:0] cm0_lrd,
  input  logic [`PREG_RANGE] cm0_pd,
  input  logic              cm1_valid,
  input  logic [LREG_W-1:0] cm1_lrd,
  input  logic [`PREG_RANGE] cm1_pd,
  input  logic [1:0]        rob_state,
  input  logic              walk0_valid,
  input  logic [LREG_W-1:0] walk0_lrd,
  input  logic [`PREG_RANGE] walk0_pd,
  input  logic              walk1_valid,
  input  logic [LREG_W-1:0] walk1_lrd,
  input  logic [`PREG_RANGE] walk1_pd,
  output logic              rename_ready
`ifdef RENAME_TABLE_DEBUG_EN
  ,
  input  logic [LREG_W-1:0] debug_lreg,
  output logic [`PREG_RANGE] debug_arch_pd,
  output logic [`PREG_RANGE] debug_spec_pd
`endif
);

  localparam int PREG_W = $bits(logic [`PREG_RANGE]);

  logic [PREG_W-1:0] r_spec      [LREG_NUM];
  logic [PREG_W-1:0] r_arch      [LREG_NUM];
  logic [PREG_W-1:0] w_spec_next [LREG_NUM];
  logic [PREG_W-1:0] w_arch_next [LREG_NUM];

  logic              w_idle;
  logic              w_rn0_we;
  logic              w_rn1_we;
  logic              w_byp;
  logic [PREG_W-1:0] w_rd0_s1, w_rd0_s2, w_rd0_d;
  logic [PREG_W-1:0] w_rd1_s1, w_rd1_s2, w_rd1_d;

  assign w_idle       = (rob_state == `ROB_STATE_IDLE);
  assign rename_ready = w_idle;
  assign w_rn0_we     = w_idle & rn0_valid & rn0_rd_wen & (rn0_lrd != '0);
  assign w_rn1_we     = w_idle & rn1_valid & rn1_rd_wen & (rn1_lrd != '0);
  // Bypass is independent of rob_state: it only shapes the combinational view.
  assign w_byp        = rn0_valid & rn0_rd_wen & (rn0_lrd != '0);

  assign w_rd0_s1 = (rn0_lrs1 == '0) ? '0 : r_spec[rn0_lrs1];
  assign w_rd0_s2 = (rn0_lrs2 == '0) ? '0 : r_spec[rn0_lrs2];
  assign w_rd0_d  = (rn0_lrd  == '0) ? '0 : r_spec[rn0_lrd];
  assign w_rd1_s1 = (rn1_lrs1 == '0) ? '0 : r_spec[rn1_lrs1];
  assign w_rd1_s2 = (rn1_lrs2 == '0) ? '0 : r_spec[rn1_lrs2];
  assign w_rd1_d  = (rn1_lrd  == '0) ? '0 : r_spec[rn1_lrd];

  always_comb begin
    rn0_prs1   = '0;
    rn0_prs2   = '0;
    rn0_old_pd = '0;
    if (rn0_valid) begin
      rn0_prs1   = w_rd0_s1;
      rn0_prs2   = w_rd0_s2;
      rn0_old_pd = w_rd0_d;
    end
  end

  // Lane 1 is younger: it must observe lane 0's fresh mapping in the same group.
  always_comb begin
    rn1_prs1   = '0;
    rn1_prs2   = '0;
    rn1_old_pd = '0;
    if (rn1_valid) begin
      rn1_prs1   = (w_byp && (rn1_lrs1 == rn0_lrd)) ? rn0_pd : w_rd1_s1;
      rn1_prs2   = (w_byp && (rn1_lrs2 == rn0_lrd)) ? rn0_pd : w_rd1_s2;
      rn1_old_pd = (w_byp && (rn1_lrd  == rn0_lrd)) ? rn0_pd : w_rd1_d;
    end
  end

  always_comb begin
    w_arch_next = r_arch;
    if (cm0_valid && (cm0_lrd != '0)) w_arch_next[cm0_lrd] = cm0_pd;
    if (cm1_valid && (cm1_lrd != '0)) w_arch_next[cm1_lrd] = cm1_pd;
  end

  // Later assignment wins, so lane 1 / walk1 override on a shared lrd.
  always_comb begin
    w_spec_next = r_spec;
    case (rob_state)
      `ROB_STATE_IDLE: begin
        if (w_rn0_we) w_spec_next[rn0_lrd] = rn0_pd;
        if (w_rn1_we) w_spec_next[rn1_lrd] = rn1_pd;
      end
      `ROB_STATE_ROLLBACK: begin
        w_spec_next = w_arch_next;
      end
      `ROB_STATE_WALK: begin
        if (walk0_valid && (walk0_lrd != '0)) w_spec_next[walk0_lrd] = walk0_pd;
        if (walk1_valid && (walk1_lrd != '0)) w_spec_next[walk1_lrd] = walk1_pd;
      end
      default: begin
        w_spec_next = r_spec;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LREG_NUM; i++) begin
        r_spec[i] <= PREG_W'(i);
        r_arch[i] <= PREG_W'(i);
      end
    end else begin
      r_spec <= w_spec_next;
      r_arch <= w_arch_next;
    end
  end

`ifdef RENAME_TABLE_DEBUG_EN
  assign debug_arch_pd = r_arch[debug_lreg];
  assign debug_spec_pd = r_spec[debug_lreg];
`endif

endmodule

`default_nettype wire

// File: tb/tb_rename_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rename_table : table-driven self-checking bench for rename_table
// Revision        : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_rename_table;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RB   = 2'd1;
  localparam logic [1:0] ST_WALK = 2'd2;
  localparam logic [1:0] ST_BAD  = 2'd3;

  logic       clock = 1'b0;
  logic       reset;
  logic       rn0_valid, rn0_rd_wen, rn1_valid, rn1_rd_wen;
  logic [4:0] rn0_lrs1, rn0_lrs2, rn0_lrd, rn1_lrs1, rn1_lrs2, rn1_lrd;
  logic [5:0] rn0_pd, rn1_pd;
  logic [5:0] rn0_prs1, rn0_prs2, rn0_old_pd, rn1_prs1, rn1_prs2, rn1_old_pd;
  logic       cm0_valid, cm1_valid, walk0_valid, walk1_valid;
  logic [4:0] cm0_lrd, cm1_lrd, walk0_lrd, walk1_lrd;
  logic [5:0] cm0_pd, cm1_pd, walk0_pd, walk1_pd;
  logic [1:0] rob_state;
  logic       rename_ready;
`ifdef RENAME_TABLE_DEBUG_EN
  logic [4:0] debug_lreg = '0;
  logic [5:0] debug_arch_pd, debug_spec_pd;
`endif

  rename_table dut (
    .clock(clock), .reset(reset),
    .rn0_valid(rn0_valid), .rn0_lrs1(rn0_lrs1), .rn0_lrs2(rn0_lrs2), .rn0_lrd(rn0_lrd),
    .rn0_rd_wen(rn0_rd_wen), .rn0_pd(rn0_pd),
    .rn0_prs1(rn0_prs1), .rn0_prs2(rn0_prs2), .rn0_old_pd(rn0_old_pd),
    .rn1_valid(rn1_valid), .rn1_lrs1(rn1_lrs1), .rn1_lrs2(rn1_lrs2), .rn1_lrd(rn1_lrd),
    .rn1_rd_wen(rn1_rd_wen), .rn1_pd(rn1_pd),
    .rn1_prs1(rn1_prs1), .rn1_prs2(rn1_prs2), .rn1_old_pd(rn1_old_pd),
    .cm0_valid(cm0_valid), .cm0_lrd(cm0_lrd), .cm0_pd(cm0_pd),
    .cm1_valid(cm1_valid), .cm1_lrd(cm1_lrd), .cm1_pd(cm1_pd),
    .rob_state(rob_state),
    .walk0_valid(walk0_valid), .walk0_lrd(walk0_lrd), .walk0_pd(walk0_pd),
    .walk1_valid(walk1_valid), .walk1_lrd(walk1_lrd), .walk1_pd(walk1_pd),
    .rename_ready(rename_ready)
`ifdef RENAME_TABLE_DEBUG_EN
    , .debug_lreg(debug_lreg), .debug_arch_pd(debug_arch_pd), .debug_spec_pd(debug_spec_pd)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [95:0] name;
    logic [1:0]  st;
    logic        v0, we0; logic [4:0] s01, s02, d0; logic [5:0] pd0;
    logic        v1, we1; logic [4:0] s11, s12, d1; logic [5:0] pd1;
    logic        c0v; logic [4:0] c0d; logic [5:0] c0p;
    logic        c1v; logic [4:0] c1d; logic [5:0] c1p;
    logic        w0v; logic [4:0] w0d; logic [5:0] w0p;
    logic        w1v; logic [4:0] w1d; logic [5:0] w1p;
    logic [5:0]  e01, e02, e0d, e11, e12, e1d;
    logic        erdy;
  } vec_t;

  typedef struct packed {
    logic [95:0] name;
    logic [36:0] exp;
  } sb_t;

  vec_t tv[$];
  sb_t  sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t f_base(input logic [95:0] nm, input logic [1:0] st);
    vec_t v;
    v      = '0;
    v.name = nm;
    v.st   = st;
    v.erdy = (st == ST_IDLE);
    return v;
  endfunction

  function automatic vec_t f_rn0(input vec_t vi, input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] d, input logic w, input logic [5:0] p,
                                 input logic [5:0] ea, input logic [5:0] eb, input logic [5:0] ed);
    vec_t v = vi;
    v.v0 = 1'b1; v.s01 = a; v.s02 = b; v.d0 = d; v.we0 = w; v.pd0 = p;
    v.e01 = ea; v.e02 = eb; v.e0d = ed;
    return v;
  endfunction

  function automatic vec_t f_rn1(input vec_t vi, input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] d, input logic w, input logic [5:0] p,
                                 input logic [5:0] ea, input logic [5:0] eb, input logic [5:0] ed);
    vec_t v = vi;
    v.v1 = 1'b1; v.s11 = a; v.s12 = b; v.d1 = d; v.we1 = w; v.pd1 = p;
    v.e11 = ea; v.e12 = eb; v.e1d = ed;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rob_state  = v.st;
    rn0_valid  = v.v0; rn0_rd_wen = v.we0; rn0_lrs1 = v.s01; rn0_lrs2 = v.s02;
    rn0_lrd    = v.d0; rn0_pd     = v.pd0;
    rn1_valid  = v.v1; rn1_rd_wen = v.we1; rn1_lrs1 = v.s11; rn1_lrs2 = v.s12;
    rn1_lrd    = v.d1; rn1_pd     = v.pd1;
    cm0_valid  = v.c0v; cm0_lrd = v.c0d; cm0_pd = v.c0p;
    cm1_valid  = v.c1v; cm1_lrd = v.c1d; cm1_pd = v.c1p;
    walk0_valid = v.w0v; walk0_lrd = v.w0d; walk0_pd = v.w0p;
    walk1_valid = v.w1v; walk1_lrd = v.w1d; walk1_pd = v.w1p;
    sb.push_back('{name: v.name,
                   exp: {v.e01, v.e02, v.e0d, v.e11, v.e12, v.e1d, v.erdy}});
  endtask

  task automatic check_pop();
    sb_t         e;
    logic [36:0] act;
    e   = sb.pop_front();
    act = {rn0_prs1, rn0_prs2, rn0_old_pd, rn1_prs1, rn1_prs2, rn1_old_pd, rename_ready};
    n_vec++;
    if (act !== e.exp) begin
      n_miss++;
      $display("FAIL %0s: got prs1/prs2/old lane0 %0d/%0d/%0d lane1 %0d/%0d/%0d rdy %0b, want %0d/%0d/%0d %0d/%0d/%0d rdy %0b",
               e.name, act[36:31], act[30:25], act[24:19], act[18:13], act[12:7], act[6:1], act[0],
               e.exp[36:31], e.exp[30:25], e.exp[24:19], e.exp[18:13], e.exp[12:7], e.exp[6:1], e.exp[0]);
    end
  endtask

  // Drive right after the edge, compare mid-cycle on the falling edge.
  task automatic step(input vec_t v);
    drive(v);
    @(negedge clock);
    check_pop();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    drive(f_base("init", ST_IDLE));
    void'(sb.pop_front());
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    tv.push_back(f_rn0(f_base("rst_read", ST_IDLE), 5, 0, 7, 0, 0, 5, 0, 7));
    tv.push_back(f_rn1(f_rn0(f_base("grp_dep", ST_IDLE), 1, 2, 3, 1, 40, 1, 2, 3),
                       3, 4, 3, 1, 41, 40, 4, 40));
    tv.push_back(f_rn1(f_rn0(f_base("read_x3", ST_IDLE), 3, 3, 3, 0, 0, 41, 41, 41),
                       0, 8, 0, 0, 0, 0, 8, 0));
    tv.push_back(f_rn1(f_rn0(f_base("x0_write", ST_IDLE), 0, 0, 0, 1, 45, 0, 0, 0),
                       0, 9, 0, 0, 0, 0, 9, 0));
    tv.push_back(f_rn0(f_base("x0_read", ST_IDLE), 0, 10, 0, 0, 0, 0, 10, 0));
    tv.push_back(f_rn1(f_rn0(f_base("x4_to_50", ST_IDLE), 4, 6, 4, 1, 50, 4, 6, 4),
                       4, 0, 11, 0, 0, 50, 0, 11));
    v = f_rn0(f_base("x4_to_51", ST_IDLE), 4, 1, 4, 1, 51, 50, 1, 50);
    v.c0v = 1; v.c0d = 4; v.c0p = 50;
    tv.push_back(v);
    v = f_rn0(f_base("rollback", ST_RB), 4, 6, 12, 1, 33, 51, 6, 12);
    v.c1v = 1; v.c1d = 6; v.c1p = 52;
    tv.push_back(v);
    tv.push_back(f_rn1(f_rn0(f_base("post_rb", ST_IDLE), 4, 6, 12, 0, 0, 50, 52, 12),
                       3, 7, 12, 0, 0, 3, 7, 12));
    v = f_rn0(f_base("walk", ST_WALK), 9, 0, 13, 1, 34, 9, 0, 13);
    v.w0v = 1; v.w0d = 9; v.w0p = 55; v.w1v = 1; v.w1d = 9; v.w1p = 56;
    tv.push_back(v);
    tv.push_back(f_rn0(f_base("post_walk", ST_IDLE), 9, 13, 9, 0, 0, 56, 13, 56));
    v = f_rn0(f_base("cm_conflict", ST_IDLE), 2, 2, 2, 0, 0, 2, 2, 2);
    v.c0v = 1; v.c0d = 2; v.c0p = 60; v.c1v = 1; v.c1d = 2; v.c1p = 61;
    tv.push_back(v);
    tv.push_back(f_rn0(f_base("rollback2", ST_RB), 2, 9, 4, 0, 0, 2, 56, 50));
    tv.push_back(f_rn1(f_rn0(f_base("post_rb2", ST_IDLE), 2, 9, 4, 0, 0, 61, 9, 50),
                       6, 3, 2, 0, 0, 52, 3, 61));
    v = f_rn0(f_base("state_11", ST_BAD), 5, 0, 5, 1, 20, 5, 0, 5);
    v.c0v = 1; v.c0d = 5; v.c0p = 21;
    tv.push_back(v);
    tv.push_back(f_rn0(f_base("post_st11", ST_IDLE), 5, 0, 0, 0, 0, 5, 0, 0));
    tv.push_back(f_base("rollback3", ST_RB));
    tv.push_back(f_rn1(f_rn0(f_base("lane_wins", ST_IDLE), 5, 0, 14, 1, 22, 21, 0, 14),
                       0, 14, 14, 1, 23, 0, 22, 22));
    tv.push_back(f_rn0(f_base("read_x14", ST_IDLE), 14, 0, 0, 0, 0, 23, 0, 0));
    tv.push_back(f_base("rb_rep_a", ST_RB));
    tv.push_back(f_base("rb_rep_b", ST_RB));
    tv.push_back(f_rn0(f_base("post_rb_rep", ST_IDLE), 14, 5, 2, 0, 0, 14, 21, 61));

    for (int i = 0; i < tv.size(); i++) step(tv[i]);

    // Reset mid-run restores identity in both tables, overriding a commit.
    step(f_rn0(f_base("pre_reset", ST_IDLE), 15, 0, 15, 1, 30, 15, 0, 15));
    v = f_base("in_reset", ST_IDLE);
    v.c0v = 1; v.c0d = 15; v.c0p = 31;
    drive(v);
    void'(sb.pop_front());
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    step(f_rn0(f_base("after_reset", ST_IDLE), 15, 2, 4, 0, 0, 15, 2, 4));
    step(f_base("rb_after_rst", ST_RB));
    step(f_rn0(f_base("arch_is_init", ST_IDLE), 15, 6, 9, 0, 0, 15, 6, 9));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
